// File: rtl/tmds_decoder.sv
// -----------------------------------------------------------------------------
// tmds_decoder
//
// Receive-side TMDS channel decoder (one instance per data channel). Takes one
// raw, unaligned 10-bit word per pixel clock from a 1:10 deserializer, finds
// symbol alignment by hunting for control tokens with a bit-slip state
// machine, and decodes each aligned symbol to 8-bit pixel data or a 2-bit
// control value.
//
// Parameters:
//   LOCK_COUNT      consecutive control tokens needed to declare lock
//   SEARCH_TIMEOUT  non-control run length in SEARCH that forces a bit-slip
//   LOSS_TIMEOUT    non-control run length in LOCKED that drops lock
//
// Ports:
//   clk_pixel   in   1  pixel clock (single clock domain)
//   reset       in   1  synchronous, active-high reset
//   din         in  10  raw deserialized word, din[0] earliest on the wire
//   de          out  1  data enable, data valid when 1
//   ctrl        out  2  control value {c1,c0}, meaningful when de = 0
//   data        out  8  decoded pixel byte
//   locked      out  1  alignment lock status
//   offset      out  4  current bit-slip offset, 0..9
//   loss_count  out 16  saturating LOCKED->SEARCH count (optional)
//
// Optional feature macro: TMDS_DEC_LOSSCNT_EN adds the loss_count port and
// its counter. Without it the port and counter do not exist.
//
// Latency: din captured at edge N -> prev at N, sym at N+1, outputs at N+2.
// -----------------------------------------------------------------------------
module tmds_decoder #(
  parameter int LOCK_COUNT     = 8,
  parameter int SEARCH_TIMEOUT = 2048,
  parameter int LOSS_TIMEOUT   = 4096
) (
  input  logic        clk_pixel,
  input  logic        reset,
  input  logic [9:0]  din,
  output logic        de,
  output logic [1:0]  ctrl,
  output logic [7:0]  data,
  output logic        locked,
  output logic [3:0]  offset
`ifdef TMDS_DEC_LOSSCNT_EN
  ,
  output logic [15:0] loss_count
`endif
);

  localparam int NCTL_MAX = (SEARCH_TIMEOUT > LOSS_TIMEOUT) ? SEARCH_TIMEOUT : LOSS_TIMEOUT;
  localparam int NCTL_W   = $clog2(NCTL_MAX + 1);
  localparam int CTL_W    = $clog2(LOCK_COUNT + 1);

  localparam logic [CTL_W-1:0]  LOCK_V     = CTL_W'(LOCK_COUNT);
  localparam logic [NCTL_W-1:0] NCTL_MAX_V = NCTL_W'(NCTL_MAX);
  localparam logic [NCTL_W-1:0] SEARCH_V   = NCTL_W'(SEARCH_TIMEOUT);
  localparam logic [NCTL_W-1:0] LOSS_V     = NCTL_W'(LOSS_TIMEOUT);

  localparam logic [9:0] TOK_00 = 10'b1101010100;
  localparam logic [9:0] TOK_01 = 10'b0010101011;
  localparam logic [9:0] TOK_10 = 10'b0101010100;
  localparam logic [9:0] TOK_11 = 10'b1010101011;

  typedef enum logic {
    ST_SEARCH = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  // ---------------------------------------------------------------------------
  // Alignment window
  // ---------------------------------------------------------------------------
  logic [9:0]  prev_reg;
  logic [9:0]  sym_reg;
  logic [9:0]  sym_next;
  logic [18:0] win;
  logic [9:0]  cand [10];

  // The largest offset (9) only reaches win bit 18, so din[9] never needs to
  // take part in the window directly; it enters through prev_reg next cycle.
  assign win = {din[8:0], prev_reg};

  genvar gi;
  generate
    for (gi = 0; gi < 10; gi++) begin : g_cand
      assign cand[gi] = win[gi +: 10];
    end
  endgenerate

  always_comb begin
    sym_next = '0;
    for (int i = 0; i < 10; i++) begin
      if (offset_reg == 4'(i)) begin
        sym_next = cand[i];
      end
    end
  end

  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      prev_reg <= '0;
      sym_reg  <= '0;
    end else begin
      prev_reg <= din;
      sym_reg  <= sym_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Symbol classification and data decode
  // ---------------------------------------------------------------------------
  logic       is_ctrl;
  logic [1:0] ctl_val;
  logic [7:0] q_word;
  logic [7:0] dec_byte;

  always_comb begin
    is_ctrl = 1'b1;
    ctl_val = 2'b00;
    case (sym_reg)
      TOK_00:  ctl_val = 2'b00;
      TOK_01:  ctl_val = 2'b01;
      TOK_10:  ctl_val = 2'b10;
      TOK_11:  ctl_val = 2'b11;
      default: is_ctrl = 1'b0;
    endcase
  end

  // Bit 9 flags an inverted payload, bit 8 selects XOR (1) or XNOR (0) chaining.
  assign q_word      = sym_reg[9] ? ~sym_reg[7:0] : sym_reg[7:0];
  assign dec_byte[0] = q_word[0];

  generate
    for (gi = 1; gi < 8; gi++) begin : g_dec
      assign dec_byte[gi] = sym_reg[8] ? (q_word[gi] ^ q_word[gi-1])
                                       : ~(q_word[gi] ^ q_word[gi-1]);
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Run counters and state-transition decisions
  // ---------------------------------------------------------------------------
  state_t            state_reg;
  logic [3:0]        offset_reg;
  logic [CTL_W-1:0]  ctl_run_reg;
  logic [NCTL_W-1:0] nctl_run_reg;
  logic [CTL_W-1:0]  ctl_run_cnt;
  logic [NCTL_W-1:0] nctl_run_cnt;
  logic              enter_lock;
  logic              slip;
  logic              lose_lock;
  logic              locked_next;
  logic              de_reg;
  logic [1:0]        ctrl_reg;
  logic [7:0]        data_reg;
  logic              locked_reg;

  // A token clears the non-control run and vice versa; both saturate.
  always_comb begin
    ctl_run_cnt  = '0;
    nctl_run_cnt = '0;
    if (is_ctrl) begin
      ctl_run_cnt = (ctl_run_reg >= LOCK_V) ? LOCK_V : ctl_run_reg + 1'b1;
    end else begin
      nctl_run_cnt = (nctl_run_reg >= NCTL_MAX_V) ? NCTL_MAX_V : nctl_run_reg + 1'b1;
    end
  end

  // Lock takes priority over slip. A token on the would-be timeout cycle
  // clears nctl_run_cnt, so it suppresses the slip without extra logic.
  always_comb begin
    enter_lock  = (state_reg == ST_SEARCH) && (ctl_run_cnt >= LOCK_V);
    slip        = (state_reg == ST_SEARCH) && !enter_lock && (nctl_run_cnt >= SEARCH_V);
    lose_lock   = (state_reg == ST_LOCKED) && (nctl_run_cnt >= LOSS_V);
    locked_next = enter_lock || ((state_reg == ST_LOCKED) && !lose_lock);
  end

`ifdef TMDS_DEC_LOSSCNT_EN
  logic [15:0] loss_count_reg;
`endif

  // ---------------------------------------------------------------------------
  // Alignment FSM with registered, gated outputs. Gating follows the state
  // being entered, so the first gated symbol appears on the same edge that
  // raises locked, and de drops on the same edge that clears it.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      state_reg      <= ST_SEARCH;
      offset_reg     <= '0;
      ctl_run_reg    <= '0;
      nctl_run_reg   <= '0;
      locked_reg     <= 1'b0;
      de_reg         <= 1'b0;
      ctrl_reg       <= 2'b00;
      data_reg       <= '0;
`ifdef TMDS_DEC_LOSSCNT_EN
      loss_count_reg <= '0;
`endif
    end else begin
      ctl_run_reg  <= ctl_run_cnt;
      nctl_run_reg <= nctl_run_cnt;

      case (state_reg)
        ST_SEARCH: begin
          if (enter_lock) begin
            state_reg  <= ST_LOCKED;
            locked_reg <= 1'b1;
          end else if (slip) begin
            offset_reg   <= (offset_reg == 4'd9) ? 4'd0 : offset_reg + 4'd1;
            ctl_run_reg  <= '0;
            nctl_run_reg <= '0;
          end
        end
        ST_LOCKED: begin
          if (lose_lock) begin
            state_reg    <= ST_SEARCH;
            locked_reg   <= 1'b0;
            ctl_run_reg  <= '0;
            nctl_run_reg <= '0;
`ifdef TMDS_DEC_LOSSCNT_EN
            if (loss_count_reg != 16'hFFFF) begin
              loss_count_reg <= loss_count_reg + 16'd1;
            end
`endif
          end
        end
        default: begin
          state_reg  <= ST_SEARCH;
          locked_reg <= 1'b0;
        end
      endcase

      if (locked_next) begin
        if (is_ctrl) begin
          de_reg   <= 1'b0;
          ctrl_reg <= ctl_val;
          data_reg <= '0;
        end else begin
          // ctrl keeps the last control value seen while data flows.
          de_reg   <= 1'b1;
          data_reg <= dec_byte;
        end
      end else begin
        de_reg   <= 1'b0;
        ctrl_reg <= 2'b00;
        data_reg <= '0;
      end
    end
  end

  assign de     = de_reg;
  assign ctrl   = ctrl_reg;
  assign data   = data_reg;
  assign locked = locked_reg;
  assign offset = offset_reg;

`ifdef TMDS_DEC_LOSSCNT_EN
  assign loss_count = loss_count_reg;
`endif

endmodule
